// File: rtl/timer_pkg.sv
// Shared definitions for the BCD countdown timer.
//   state_t        : controller state encoding
//   DIGIT_W        : width of one BCD digit
//   DIGIT_MAX_MMSS : default per-digit maxima for an MM:SS display (59:59)
//   clamp_digit()  : limits a loaded digit to the digit's maximum
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int DIGIT_W = 4;

  localparam logic [15:0] DIGIT_MAX_MMSS = 16'h5959;

  // A loaded nibble above the digit maximum is replaced by the maximum.
  function automatic logic [DIGIT_W-1:0] clamp_digit(
    input logic [DIGIT_W-1:0] value,
    input logic [DIGIT_W-1:0] max_value
  );
    logic [DIGIT_W-1:0] result;
    if (value > max_value) begin
      result = max_value;
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One down-counting digit of the countdown chain.
//   clk        : system clock, rising edge
//   clear      : asynchronous active-low reset (digit -> 0)
//   max_val    : largest value of this digit (modulus - 1)
//   load_en    : parallel load strobe (active high, already decoded)
//   load_val   : value to load, clamped to max_val
//   dec_en     : chain-wide decrement enable for this cycle
//   borrow_in  : borrow from the less significant digit (1 for digit 0)
//   digit      : current digit value, registered
//   borrow_out : this digit wraps from 0 to max_val and borrows upward
//   is_zero    : digit currently reads 0
module bcd_digit_down
  import timer_pkg::*;
(
  input  logic               clk,
  input  logic               clear,
  input  logic [DIGIT_W-1:0] max_val,
  input  logic               load_en,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               dec_en,
  input  logic               borrow_in,
  output logic [DIGIT_W-1:0] digit,
  output logic               borrow_out,
  output logic               is_zero
);

  // Zero detect and borrow propagation; purely combinational so the whole
  // chain settles within one cycle.
  always_comb begin
    is_zero    = (digit == 4'd0);
    borrow_out = borrow_in & is_zero;
  end

  // Digit register: load has priority over decrement.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      digit <= 4'd0;
    end else if (load_en) begin
      digit <= clamp_digit(load_val, max_val);
    end else if (dec_en && borrow_in) begin
      if (is_zero) begin
        digit <= max_val;
      end else begin
        digit <= digit - 4'd1;
      end
    end else begin
      digit <= digit;
    end
  end

endmodule

// File: rtl/countdown_timer_bcd.sv
// Multi-digit BCD countdown timer with IDLE/RUN/PAUSED/DONE controller.
// Decrements once per tick while running and holds at zero.
//   clk   : system clock, rising edge
//   clear : asynchronous active-low reset
//   tick  : one-cycle count-enable strobe (1 Hz)
//   data  : parallel load value, one BCD digit per nibble
//   load  : synchronous active-low parallel load (highest priority)
//   run   : start / resume request
//   stop  : active-low pause
//   count : current value, registered
//   tc    : count == 0 (combinational from count)
//   busy  : registered, high in RUN or PAUSED
//   done  : registered, one-cycle pulse when the count reaches zero
module countdown_timer_bcd
  import timer_pkg::*;
#(
  parameter int                          NUM_DIGITS = 4,
  parameter logic [DIGIT_W*NUM_DIGITS-1:0] DIGIT_MAX  = DIGIT_MAX_MMSS
) (
  input  logic                          clk,
  input  logic                          clear,
  input  logic                          tick,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] data,
  input  logic                          load,
  input  logic                          run,
  input  logic                          stop,
  output logic [DIGIT_W*NUM_DIGITS-1:0] count,
  output logic                          tc,
  output logic                          busy,
  output logic                          done
);

  state_t                state_r;
  state_t                state_nxt_s;
  logic                  dec_en_s;
  logic                  count_one_s;
  logic [NUM_DIGITS:0]   borrow_s;
  logic [NUM_DIGITS-1:0] is_zero_s;

  assign borrow_s[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      bcd_digit_down u_digit (
        .clk        (clk),
        .clear      (clear),
        .max_val    (DIGIT_MAX[DIGIT_W*gi +: DIGIT_W]),
        .load_en    (~load),
        .load_val   (data[DIGIT_W*gi +: DIGIT_W]),
        .dec_en     (dec_en_s),
        .borrow_in  (borrow_s[gi]),
        .digit      (count[DIGIT_W*gi +: DIGIT_W]),
        .borrow_out (borrow_s[gi+1]),
        .is_zero    (is_zero_s[gi])
      );
    end
  endgenerate

  // Terminal count and "one step from zero": a decrement reaches zero only
  // when digit 0 is 1 and every higher digit is already 0.
  always_comb begin
    tc          = &is_zero_s;
    count_one_s = (count[DIGIT_W-1:0] == 4'd1);
    for (int i = 1; i < NUM_DIGITS; i++) begin
      count_one_s = count_one_s & is_zero_s[i];
    end
  end

  // Controller next state and decrement enable; priority load > stop > run > tick.
  // Decrement is also gated by tc so a forced tick at zero cannot wrap.
  always_comb begin
    state_nxt_s = state_r;
    dec_en_s    = 1'b0;
    if (!load) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (run && !tc) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!stop) begin
            state_nxt_s = ST_PAUSED;
          end else if (tick && !tc) begin
            dec_en_s = 1'b1;
            if (count_one_s) begin
              state_nxt_s = ST_DONE;
            end else begin
              state_nxt_s = ST_RUN;
            end
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_PAUSED: begin
          if (stop && run) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_PAUSED;
          end
        end
        ST_DONE: begin
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // busy/done are decoded from the next state so they line up with it.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_PAUSED);
      done <= (state_nxt_s == ST_DONE);
    end
  end

endmodule

// File: tb/tb_countdown_timer_bcd.sv
module tb_countdown_timer_bcd;

  localparam logic [15:0] DM = 16'h5959;

  typedef struct packed {
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic        tc;
  } exp_t;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        tick = 1'b0;
  logic [15:0] data = 16'h0000;
  logic        load = 1'b1;
  logic        run = 1'b0;
  logic        stop = 1'b1;
  logic [15:0] count;
  logic        tc, busy, done;

  logic        tick2 = 1'b0;
  logic [7:0]  data2 = 8'h00;
  logic        load2 = 1'b1;
  logic        run2 = 1'b0;
  logic        stop2 = 1'b1;
  logic [7:0]  count2;
  logic        tc2, busy2, done2;

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];

  // Reference model: the count as a single mixed-radix integer.
  int mval = 0;
  int mst  = 0;   // 0 idle, 1 run, 2 paused, 3 done

  countdown_timer_bcd dut (
    .clk(clk), .clear(clear), .tick(tick), .data(data), .load(load),
    .run(run), .stop(stop), .count(count), .tc(tc), .busy(busy), .done(done)
  );

  countdown_timer_bcd #(.NUM_DIGITS(2), .DIGIT_MAX(8'h99)) dut2 (
    .clk(clk), .clear(clear), .tick(tick2), .data(data2), .load(load2),
    .run(run2), .stop(stop2), .count(count2), .tc(tc2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  function automatic int to_val(input logic [15:0] d);
    logic [15:0] dm;
    int v, w, m, x;
    dm = DM; v = 0; w = 1;
    for (int i = 0; i < 4; i++) begin
      m = int'(dm[4*i +: 4]);
      x = int'(d[4*i +: 4]);
      if (x > m) x = m;
      v += x * w;
      w *= (m + 1);
    end
    return v;
  endfunction

  function automatic logic [15:0] to_digits(input int val);
    logic [15:0] dm, r;
    int v, m;
    dm = DM; v = val; r = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      m = int'(dm[4*i +: 4]);
      r[4*i +: 4] = 4'(v % (m + 1));
      v = v / (m + 1);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // One clock edge of stimulus; the model predicts the post-edge outputs.
  task automatic step(input logic ld, input logic st, input logic rn,
                      input logic tk, input logic [15:0] dt);
    exp_t e;
    @(posedge clk); #2;
    load = ld; stop = st; run = rn; tick = tk; data = dt;
    if (!ld) begin
      mval = to_val(dt);
      mst  = 0;
    end else begin
      case (mst)
        0: if (rn && mval != 0) mst = 1;
        1: begin
          if (!st) mst = 2;
          else if (tk && mval > 0) begin
            mval = mval - 1;
            if (mval == 0) mst = 3;
          end
        end
        2: if (st && rn) mst = 1;
        default: mst = 0;
      endcase
    end
    e.count = to_digits(mval);
    e.busy  = (mst == 1) || (mst == 2);
    e.done  = (mst == 3);
    e.tc    = (mval == 0);
    exp_q.push_back(e);
  endtask

  task automatic idle_step();
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(posedge clk); #2;
    load = 1'b1; stop = 1'b1; run = 1'b0; tick = 1'b0;
    while (exp_q.size() != 0 && n < 10) begin
      @(posedge clk); #2;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Asynchronous clear applied between edges; outputs must change at once.
  task automatic do_clear();
    @(posedge clk); #2;
    load = 1'b1; stop = 1'b1; run = 1'b0; tick = 1'b0;
    clear = 1'b0;
    #1;
    check("clear_count", count, 16'h0000);
    check("clear_tc", {15'd0, tc}, 16'h0001);
    check("clear_busy", {15'd0, busy}, 16'h0000);
    check("clear_done", {15'd0, done}, 16'h0000);
    mval = 0; mst = 0;
    @(posedge clk); #2;
    clear = 1'b1;
  endtask

  // Monitor: every edge the DUT presents a new output; compare against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("count", count, e.count);
        check("busy", {15'd0, busy}, {15'd0, e.busy});
        check("done", {15'd0, done}, {15'd0, e.done});
        check("tc", {15'd0, tc}, {15'd0, e.tc});
      end
    end
  end

  initial begin
    logic [31:0] r;
    logic [15:0] dt;
    #12;
    clear = 1'b1;

    // 1. reset mid-run at 12:34, then load 0105
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h1234);
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000);
    drain();
    do_clear();
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0105);
    idle_step();

    // 2. countdown to zero, done pulse, hold at zero
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0003);
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000);

    // 3. borrow chain
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h1000);
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0100);
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000);

    // 4. pause with tick on the same edge, ticks while paused, resume
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0030);
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000);
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000);
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000);

    // 5. clamp, and run from zero stays idle
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h7A9F);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000);
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);

    // 6. priority: load beats stop and tick while running
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0200);
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0042);
    idle_step();

    // Random phase: biased toward small loads so zero is reached often.
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      if ($urandom_range(0, 1) == 1) dt = r[15:0];
      else dt = {12'h000, 4'($urandom_range(0, 4))};
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 1), dt);
    end
    drain();

    // 6b. two-digit instance with all-9 maxima: 10 -> 09
    @(posedge clk); #2;
    load2 = 1'b0; data2 = 8'h10;
    @(posedge clk); #1;
    check("d2_load", {8'h00, count2}, 16'h0010);
    #1; load2 = 1'b1; run2 = 1'b1;
    @(posedge clk); #1;
    check("d2_busy", {15'd0, busy2}, 16'h0001);
    #1; run2 = 1'b0; tick2 = 1'b1;
    @(posedge clk); #1;
    check("d2_dec", {8'h00, count2}, 16'h0009);
    check("d2_done", {15'd0, done2}, 16'h0000);
    #1; tick2 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
